// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: issue, MT* write and HI/LO result bundle between control path and the mul/div unit
interface muldiv_hilo_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master (output start, op, a, b, mthi, mtlo, wdata, input busy, done, div_zero, hi, lo);
  modport slave (input start, op, a, b, mthi, mtlo, wdata, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative MIPS multiply/divide unit (32 CALC cycles + FIX) owning the HI/LO registers
module muldiv_hilo #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset_n,
  muldiv_hilo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [1:0] op_r;
  logic neg_q, neg_r, done, div_zero;
  logic [5:0] cnt;
  logic [XLEN-1:0] ma, mb, rem, hi, lo, diff, quo, rmd, abs_a, abs_b;
  logic [XLEN:0] sum, t;
  logic [2*XLEN-1:0] acc, prod;
  logic sgn, is_div, borrow, dz;
  // ma holds multiplicand or dividend/quotient, mb holds multiplier or divisor
  always_comb begin
    sgn = ~op_r[0];
    is_div = op_r[1];
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (mb[0] ? {1'b0, ma} : '0);
    t = {rem, ma[XLEN-1]};
    borrow = t < {1'b0, mb};
    diff = t[XLEN-1:0] - mb;
    dz = mb == '0;
    prod = sgn && neg_q ? -acc : acc;
    quo = dz ? '1 : sgn && neg_q ? -ma : ma;
    rmd = sgn && neg_r ? -rem : rem;
    abs_a = !bus.op[0] && bus.a[XLEN-1] ? -bus.a : bus.a;
    abs_b = !bus.op[0] && bus.b[XLEN-1] ? -bus.b : bus.b;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          op_r <= bus.op;
          ma <= abs_a;
          mb <= abs_b;
          neg_q <= bus.a[XLEN-1] ^ bus.b[XLEN-1];
          neg_r <= bus.a[XLEN-1];
          acc <= '0;
          rem <= '0;
          cnt <= '0;
          div_zero <= 1'b0;
          state <= CALC;
        end else begin
          if (bus.mthi) hi <= bus.wdata;
          if (bus.mtlo) lo <= bus.wdata;
        end
        CALC: begin
          if (is_div) begin
            rem <= borrow ? t[XLEN-1:0] : diff;
            ma <= {ma[XLEN-2:0], ~borrow};
          end else begin
            acc <= {sum, acc[XLEN-1:1]};
            mb <= mb >> 1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          hi <= is_div ? rmd : prod[2*XLEN-1:XLEN];
          lo <= is_div ? quo : prod[XLEN-1:0];
          div_zero <= is_div && dz;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed and randomized checks of muldiv_hilo against an arithmetic reference model
module tb_muldiv_hilo;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  muldiv_hilo_if bus();
  muldiv_hilo dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, q, r;
    longint p;
    sx = x;
    sy = y;
    if (o == 2'b00) begin
      p = longint'(sx) * longint'(sy);
      return p;
    end
    if (o == 2'b01) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 2'b11) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sx / sy;
    r = sx % sy;
    return {r, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issues at the next edge; returns one cycle after FIX (the done cycle), ready for back-to-back issue
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit meddle,
                       output logic [31:0] rh, output logic [31:0] rl, output int nb, output int nd);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    nb = 0;
    nd = 0;
    tick;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    for (int i = 0; i <= 33; i++) begin
      if (i > 0) tick;
      if (meddle && i == 5) begin
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.a = 32'd1;
        bus.b = 32'd1;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.wdata = 32'h5555_AAAA;
      end
      if (meddle && i == 7) begin
        bus.start = 1'b0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
      end
      if (bus.busy) nb++;
      if (bus.done) nd++;
    end
    rh = bus.hi;
    rl = bus.lo;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy/done/dz=%b exp 000", {bus.busy, bus.done, bus.div_zero});
    end
    checks++;
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++;
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    logic [1:0] to[8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] ta[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'd10, 32'h8000_0000};
    logic [31:0] tb[8] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] eh[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'd1, 32'd0};
    logic [31:0] el[8] = '{32'hFFFF_FFFA, 32'd1, 32'd1, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000};
    logic ez[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] rh, rl;
    int nb, nd;
    for (int i = 0; i < 8; i++) begin
      do_op(to[i], ta[i], tb[i], 1'b0, rh, rl, nb, nd);
      checks++;
      if (rh !== eh[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, rh, eh[i]); end
      checks++;
      if (rl !== el[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, rl, el[i]); end
      checks++;
      if (nb != 33) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp 33", i, nb); end
      checks++;
      if (nd != 1) begin errors++; $display("FAIL dir%0d_done_pulses got %0d exp 1", i, nd); end
      checks++;
      if (bus.div_zero !== ez[i]) begin errors++; $display("FAIL dir%0d_div_zero got %b exp %b", i, bus.div_zero, ez[i]); end
    end
  endtask

  task automatic test_mt;
    bus.mthi = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    tick;
    bus.mthi = 1'b0;
    checks++;
    if (bus.hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi got %h exp deadbeef", bus.hi); end
    bus.mtlo = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    tick;
    bus.mtlo = 1'b0;
    checks++;
    if (bus.lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo got %h exp 0badf00d", bus.lo); end
    checks++;
    if (bus.hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_keeps_hi got %h exp deadbeef", bus.hi); end
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.wdata = 32'h1234_5678;
    tick;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== {2{32'h1234_5678}}) begin
      errors++;
      $display("FAIL mt_both got %h/%h exp 12345678/12345678", bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_mthi;
    logic [31:0] rh, rl;
    int nb, nd;
    bus.mthi = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    do_op(2'b00, 32'd5, 32'hFFFF_FFFD, 1'b0, rh, rl, nb, nd);
    checks++;
    if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL start_mthi got %h/%h exp ffffffff/fffffff1", rh, rl);
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] rh, rl;
    int nb, nd;
    do_op(2'b01, 32'd6, 32'd7, 1'b1, rh, rl, nb, nd);
    checks++;
    if ({rh, rl} !== {32'd0, 32'd42}) begin errors++; $display("FAIL busy_ignore got %h/%h exp 0/2a", rh, rl); end
    checks++;
    if (nb != 33 || nd != 1) begin errors++; $display("FAIL busy_ignore_timing got busy=%0d done=%0d exp 33/1", nb, nd); end
  endtask

  task automatic test_random;
    logic [31:0] rh, rl, x, y;
    logic [1:0] o;
    logic [63:0] e;
    int nb, nd;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom_range(0, 1) == 1 ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 1000));
      e = model(o, x, y);
      do_op(o, x, y, 1'b0, rh, rl, nb, nd);
      checks++;
      if ({rh, rl} !== e) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h/%h exp %h/%h", i, o, x, y, rh, rl, e[63:32], e[31:0]);
      end
      checks++;
      if (bus.div_zero !== (o[1] && y == 32'd0)) begin
        errors++;
        $display("FAIL rand%0d_div_zero got %b exp %b", i, bus.div_zero, o[1] && y == 32'd0);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rh, rl;
    int nb, nd;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'h1357_9BDF;
    bus.b = 32'h2468_ACE0;
    tick;
    bus.start = 1'b0;
    repeat (10) tick;
    reset_n = 1'b0;
    tick;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", bus.busy); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("FAIL mid_reset_hilo got %h/%h exp 0/0", bus.hi, bus.lo); end
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (bus.done) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL mid_reset_done got %0d pulses exp 0", nd); end
    do_op(2'b01, 32'd6, 32'd7, 1'b0, rh, rl, nb, nd);
    checks++;
    if ({rh, rl} !== {32'd0, 32'd42}) begin errors++; $display("FAIL after_reset_op got %h/%h exp 0/2a", rh, rl); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    bus.wdata = 32'd0;
    test_reset;
    test_directed;
    test_mt;
    test_start_mthi;
    test_busy_ignore;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit owning the architectural HI/LO registers; it sits beside the ALU and executes MULT, MULTU, DIV and DIVU over multiple cycles. The control path issues an operation with both source register values, stalls on `busy`, and reads results through the `hi`/`lo` outputs for MFHI/MFLO. MTHI/MTLO writes go straight to the registers when the unit is idle.

## Interface
- `XLEN`, 32, operand and HI/LO width; fixed at 32 for MIPS.
- `clk`  in  1  rising-edge clock; sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  issue operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs: multiplicand or dividend.
- `b`  in  32  rt: multiplier or divisor.
- `mthi`  in  1  write `wdata` into HI (MTHI).
- `mtlo`  in  1  write `wdata` into LO (MTLO).
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; control path stalls MF*/MT*/mul/div.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `div_zero`  out  1  registered; set by a divide with `b`==0, cleared by the next start.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE + `start`: latch op; signed ops (MULT, DIV) store |a|, |b| (two's-complement negate when bit 31 set) plus sign flags `neg_q` = a[31]^b[31], `neg_r` = a[31]; unsigned ops store raw values. Clear 64-bit accumulator and 6-bit counter; clear `div_zero`; go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle (LSB first), 64-bit product accumulated.
- CALC, divide: restoring, one quotient bit per cycle (MSB first); 33-bit partial remainder, subtract-and-test, quotient bit = no-borrow.
- CALC lasts exactly 32 cycles (counter 0..31), then FIX.
- FIX: multiply: negate 64-bit product if signed and `neg_q`; HI = product[63:32], LO = product[31:0]. Divide: LO = quotient (negated if signed and `neg_q`), HI = remainder (negated if signed and `neg_r`). Assert `done` next cycle; go to IDLE.
- Divide by zero (`b`==0): LO = 32'hFFFF_FFFF, HI = `a` (original, unmodified), `div_zero` = 1, same latency as a normal divide.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (natural wrap, no flag).
- MTHI/MTLO: applied on the edge sampling them only in IDLE with `start`=0; ignored while busy or when `start` is high the same cycle (start has priority). `mthi` and `mtlo` together write both.
- `start` while busy: ignored, no queuing.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0; takes priority over everything, including mid-operation (operation discarded, HI/LO cleared).
- Start accepted at edge E0: `busy`=1 from after E0; CALC edges E1..E32; FIX at E33 writes HI/LO; after E33 `busy`=0 and `done`=1 for exactly one cycle.
- Total latency: 33 cycles from start edge to valid HI/LO; new `start` accepted at E34 (the `done` cycle); back-to-back issue gives one op per 34 cycles.
- `hi`/`lo` are direct register outputs; they hold previous values throughout CALC and change only at FIX, MT* or reset.
- MT* write visible on `hi`/`lo` the cycle after the sampling edge.

## Test plan
- MULT a=0xFFFF_FFFE (-2), b=0x0000_0003 -> after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, `done` pulses once, `busy` high exactly 33 cycles.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001; MULT with same operands -> HI=0, LO=1.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); DIVU a=100, b=7 -> LO=14, HI=2.
- DIV a=0x1234, b=0 -> LO=0xFFFF_FFFF, HI=0x1234, `div_zero`=1; next DIVU 10/3 clears `div_zero`, gives LO=3, HI=1. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- MTHI 0xDEAD_BEEF in IDLE -> `hi`=0xDEAD_BEEF next cycle; `mtlo` and second `start` during busy -> no effect, result of first op unchanged; `start`+`mthi` same IDLE cycle -> op runs, HI not written by MTHI.
- Assert `reset_n`=0 at CALC cycle 10 of a MULTU -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse; fresh MULTU 6*7 afterward -> LO=42, HI=0.
